// File: rtl/pipe_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipeline hazard controller.
//   state_t         : controller FSM states (RUN, MUL_BUSY)
//   MUL_CYCLES_DEF  : default EX-stage occupancy of a multi-cycle instruction
//   REG_IDX_W       : register-index width (32 architectural registers)
//   CNT_W           : width of the multi-cycle down-counter
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MUL_BUSY = 1'b1
    } state_t;

    localparam int MUL_CYCLES_DEF = 4;
    localparam int REG_IDX_W      = 5;
    localparam int CNT_W          = 4;

endpackage

// File: rtl/load_use_detect.sv
// ---------------------------------------------------------------------------
// load_use_detect
// Purely combinational load-use hazard comparator. Flags a hazard when the
// instruction in EX is a load writing a non-zero register that the
// instruction in ID reads as either source.
//   i_rs1, i_rs2 : source registers of the ID instruction
//   i_rd         : destination register of the EX instruction
//   i_memread    : EX instruction is a load
//   o_hazard     : load-use hazard present
// ---------------------------------------------------------------------------
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_IDX_W-1:0] i_rs1,
    input  logic [REG_IDX_W-1:0] i_rs2,
    input  logic [REG_IDX_W-1:0] i_rd,
    input  logic                 i_memread,
    output logic                 o_hazard
);

    logic w_rd_nonzero;
    logic w_match;

    // x0 is hard-wired to zero, so a load "to" x0 never creates a dependency.
    assign w_rd_nonzero = (i_rd != '0);
    assign w_match      = (i_rd == i_rs1) || (i_rd == i_rs2);
    assign o_hazard     = i_memread && w_rd_nonzero && w_match;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
// Stall/flush controller for a 5-stage pipeline. Handles, highest priority
// first: a global memory freeze, multi-cycle (mul/div) EX occupancy, taken
// branch flush, and load-use bubbles.
//
// Ports
//   clk, rst         : clock, asynchronous active-high reset
//   id_rs1, id_rs2   : ID-stage source registers
//   ex_rd            : EX-stage destination register
//   ex_memread       : EX instruction is a load
//   ex_mul           : EX instruction is multi-cycle
//   ex_branch_taken  : EX branch resolved taken
//   mem_busy         : data memory not ready, freeze everything
//   *_load           : load enables for PC and IF/ID, ID/EX, EX/MEM, MEM/WB
//   *_flush          : insert a bubble into that register on the next edge
//   stall            : NOT pc_load
//   stall_cycles     : running count of cycles with stall=1 (wraps)
//   dbg_state        : current FSM state, for observation only
//
// All load/flush outputs are combinational from state, counter and inputs;
// only the FSM, the down-counter and stall_cycles are registered.
// MUL_CYCLES legal range is 2..16.
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 ex_memread,
    input  logic                 ex_mul,
    input  logic                 ex_branch_taken,
    input  logic                 mem_busy,
    output logic                 pc_load,
    output logic                 ifid_load,
    output logic                 idex_load,
    output logic                 exmem_load,
    output logic                 memwb_load,
    output logic                 ifid_flush,
    output logic                 idex_flush,
    output logic                 exmem_flush,
    output logic                 stall,
    output logic [31:0]          stall_cycles,
    output state_t               dbg_state
);

    // The entry cycle is itself one stall cycle, so the counter covers the
    // remaining MUL_CYCLES-2 stalls before the release cycle.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_CYCLES - 2);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [31:0]      r_stall_cycles;
    logic             w_load_use;

    load_use_detect u_load_use_detect (
        .i_rs1     (id_rs1),
        .i_rs2     (id_rs2),
        .i_rd      (ex_rd),
        .i_memread (ex_memread),
        .o_hazard  (w_load_use)
    );

    always_comb begin
        // Default: RUN, no hazard -- everything advances, nothing flushed.
        pc_load     = 1'b1;
        ifid_load   = 1'b1;
        idex_load   = 1'b1;
        exmem_load  = 1'b1;
        memwb_load  = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;

        if (mem_busy) begin
            // Global freeze: nothing moves, FSM and counter hold.
            pc_load    = 1'b0;
            ifid_load  = 1'b0;
            idex_load  = 1'b0;
            exmem_load = 1'b0;
            memwb_load = 1'b0;
        end else if (r_state == MUL_BUSY) begin
            if (r_cnt != '0) begin
                // Hold PC..ID/EX, feed bubbles into EX/MEM while EX is busy.
                pc_load     = 1'b0;
                ifid_load   = 1'b0;
                idex_load   = 1'b0;
                exmem_flush = 1'b1;
                w_cnt_nxt   = r_cnt - 1'b1;
            end else begin
                // Release cycle: the instruction leaves EX. A following
                // ex_mul is only seen as a fresh entry next cycle.
                w_state_nxt = RUN;
            end
        end else if (ex_mul) begin
            pc_load     = 1'b0;
            ifid_load   = 1'b0;
            idex_load   = 1'b0;
            exmem_flush = 1'b1;
            w_state_nxt = MUL_BUSY;
            w_cnt_nxt   = CNT_LOAD;
            // MUL_CYCLES == 2 loads zero: one stall, then release.
        end else if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (w_load_use) begin
            // Hold PC and IF/ID, push one bubble into ID/EX.
            pc_load    = 1'b0;
            ifid_load  = 1'b0;
            idex_flush = 1'b1;
        end
    end

    assign stall = ~pc_load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= RUN;
            r_cnt          <= '0;
            r_stall_cycles <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (stall) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign dbg_state    = r_state;

endmodule
